// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer_pkg
// Brief    : Register map, CTRL bit layout and helpers for bus_timer.
// Revision : 1.0 - initial release
// ============================================================================
package bus_timer_pkg;

   // Register offsets within the 8-byte window (i_addr[2:0])
   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_STATUS    = 3'd1;
   localparam logic [2:0] REG_RELOAD_LO = 3'd2;
   localparam logic [2:0] REG_RELOAD_HI = 3'd3;
   localparam logic [2:0] REG_COUNT_LO  = 3'd4;
   localparam logic [2:0] REG_COUNT_HI  = 3'd5;
   localparam logic [2:0] REG_PRESCALE  = 3'd6;

   // CTRL bit positions
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_AUTO_BIT   = 1;
   localparam int CTRL_IRQ_EN_BIT = 2;

   // Field order puts en at bit 0, matching the bit constants above
   typedef struct packed {
      logic irq_en;
      logic auto_rl;
      logic en;
   } ctrl_t;

   // CTRL as seen on the bus: upper five bits read as zero
   function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
      logic [7:0] b;
      b = 8'h00;
      b[CTRL_EN_BIT]     = c.en;
      b[CTRL_AUTO_BIT]   = c.auto_rl;
      b[CTRL_IRQ_EN_BIT] = c.irq_en;
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Brief    : 8-bit prescale counter producing a one-cycle tick every
//            (i_div+1) enabled cycles; held at zero when disabled or cleared.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler (
   input  logic       i_clk,
   input  logic       i_rst,   // asynchronous, active-low
   input  logic       i_en,
   input  logic       i_clr,
   input  logic [7:0] i_div,
   output logic       o_tick
);

   logic [7:0] r_cnt;
   logic       w_match;

   assign w_match = (r_cnt == i_div);
   // A clear on the same edge suppresses the tick so a restart never expires
   assign o_tick  = i_en & ~i_clr & w_match;

   // Count up while enabled, wrapping to zero on the tick edge
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= 8'h00;
      end else if (i_clr || !i_en || w_match) begin
         r_cnt <= 8'h00;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer
// Brief    : Memory-mapped 16-bit interval timer on the 6502 bus, with
//            BRAM-matched one-cycle read latency and a level IRQ output.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timer
   import bus_timer_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
   input  logic        i_clk,
   input  logic        i_rst,   // asynchronous, active-low
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_data,
   input  logic        i_rw,
   output logic [7:0]  o_data,
   output logic        o_sel,
   output logic        o_irq
);

   ctrl_t       r_ctrl;
   logic        r_expired;
   logic [15:0] r_reload;
   logic [15:0] r_count;
   logic [7:0]  r_shadow;
   logic [7:0]  r_prescale;
   logic [7:0]  r_rdata;
   logic        r_sel;

   logic        w_hit;
   logic        w_wr;
   logic        w_rd;
   logic [2:0]  w_off;
   logic        w_restart;
   logic        w_tick;
   logic        w_expire;
   logic [7:0]  w_rdmux;

   assign w_hit     = (i_addr[15:3] == BASE_ADDR[15:3]);
   assign w_wr      = w_hit & ~i_rw;
   assign w_rd      = w_hit &  i_rw;
   assign w_off     = i_addr[2:0];
   assign w_restart = w_wr && (w_off == REG_COUNT_LO);
   // Tick is already masked by restart inside the prescaler
   assign w_expire  = w_tick && (r_count == 16'h0000);

   tick_prescaler u_prescaler (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (r_ctrl.en),
      .i_clr  (w_restart),
      .i_div  (r_prescale),
      .o_tick (w_tick)
   );

   // CTRL: a CPU write takes priority over the one-shot EN clear
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_ctrl <= '0;
      end else if (w_wr && (w_off == REG_CTRL)) begin
         r_ctrl <= ctrl_t'(i_data[2:0]);
      end else if (w_expire && !r_ctrl.auto_rl) begin
         r_ctrl.en <= 1'b0;
      end
   end

   // EXPIRED: hardware set beats a simultaneous W1C
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_expired <= 1'b0;
      end else if (w_expire) begin
         r_expired <= 1'b1;
      end else if (w_wr && (w_off == REG_STATUS) && i_data[0]) begin
         r_expired <= 1'b0;
      end
   end

   // RELOAD and PRESCALE plain byte registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_reload   <= 16'h0000;
         r_prescale <= 8'h00;
      end else if (w_wr) begin
         if (w_off == REG_RELOAD_LO) r_reload[7:0]  <= i_data;
         if (w_off == REG_RELOAD_HI) r_reload[15:8] <= i_data;
         if (w_off == REG_PRESCALE)  r_prescale     <= i_data;
      end
   end

   // Down-counter: restart wins over a tick; zero reloads instead of wrapping
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_count <= 16'h0000;
      end else if (w_restart) begin
         r_count <= r_reload;
      end else if (w_tick) begin
         if (r_count == 16'h0000) r_count <= r_reload;
         else                     r_count <= r_count - 16'd1;
      end
   end

   // Register read mux
   always_comb begin
      w_rdmux = 8'h00;
      case (w_off)
         REG_CTRL:      w_rdmux = ctrl_to_byte(r_ctrl);
         REG_STATUS:    w_rdmux = {7'b0, r_expired};
         REG_RELOAD_LO: w_rdmux = r_reload[7:0];
         REG_RELOAD_HI: w_rdmux = r_reload[15:8];
         REG_COUNT_LO:  w_rdmux = r_count[7:0];
         REG_COUNT_HI:  w_rdmux = r_shadow;
         REG_PRESCALE:  w_rdmux = r_prescale;
         default:       w_rdmux = 8'h00;
      endcase
   end

   // Registered read port; COUNT_LO read snapshots the high byte
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rdata  <= 8'h00;
         r_sel    <= 1'b0;
         r_shadow <= 8'h00;
      end else begin
         r_sel   <= w_rd;
         r_rdata <= w_rd ? w_rdmux : 8'h00;
         if (w_rd && (w_off == REG_COUNT_LO)) r_shadow <= r_count[15:8];
      end
   end

   assign o_data = r_rdata;
   assign o_sel  = r_sel;
   assign o_irq  = r_expired & r_ctrl.irq_en;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_timer
// Brief    : Directed self-checking bench for bus_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        rw;
   logic [7:0]  rdata;
   logic        sel;
   logic        irq;

   int checks;
   int errors;

   bus_timer #(.BASE_ADDR(16'hFE00)) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .i_addr (addr),
      .i_data (wdata),
      .i_rw   (rw),
      .o_data (rdata),
      .o_sel  (sel),
      .o_irq  (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus write; the accepting edge is the posedge inside this task
   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wdata = d; rw = 1'b0;
      @(posedge clk);
      #1;
      addr = 16'h0000; rw = 1'b1; wdata = 8'h00;
   endtask

   // One bus read; returns data/select sampled 1 ns after the loading edge
   task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic s);
      @(negedge clk);
      addr = a; rw = 1'b1;
      @(posedge clk);
      #1;
      d = rdata; s = sel;
      addr = 16'h0000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [7:0] d; logic s;
      rst_n = 1'b0; addr = 16'h0000; wdata = 8'h00; rw = 1'b1;
      idle(3);
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_odata got %h want 00", rdata); end
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_osel got %b want 0", sel); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
      @(negedge clk); rst_n = 1'b1;
      rd(16'hFE03, d, s);
      checks++; if (d !== 8'h00 || s !== 1'b1) begin errors++; $display("FAIL reset_reload_hi got %h/%b want 00/1", d, s); end
   endtask

   task automatic test_auto_reload;
      wr(16'hFE06, 8'h00);
      wr(16'hFE02, 8'h03);
      wr(16'hFE03, 8'h00);
      wr(16'hFE04, 8'h00);
      wr(16'hFE00, 8'h07);            // E0
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (irq !== (k >= 4)) begin errors++; $display("FAIL auto_irq_E%0d got %b want %b", k, irq, (k >= 4)); end
      end
      wr(16'hFE01, 8'h01);            // W1C at E5
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL auto_w1c_irq got %b want 0", irq); end
      for (int k = 6; k <= 8; k++) begin
         @(posedge clk); #1;
         checks++;
         if (irq !== (k >= 8)) begin errors++; $display("FAIL auto_irq2_E%0d got %b want %b", k, irq, (k >= 8)); end
      end
      wr(16'hFE00, 8'h00);
      wr(16'hFE01, 8'h01);
   endtask

   task automatic test_one_shot;
      logic [7:0] d; logic s;
      wr(16'hFE04, 8'h00);            // restart, count = 3
      wr(16'hFE00, 8'h05);            // E0
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (irq !== (k >= 4)) begin errors++; $display("FAIL oneshot_irq_E%0d got %b want %b", k, irq, (k >= 4)); end
      end
      rd(16'hFE00, d, s);
      checks++; if (d !== 8'h04) begin errors++; $display("FAIL oneshot_ctrl got %h want 04", d); end
      wr(16'hFE01, 8'h01);
      idle(20);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_no_reexpire got %b want 0", irq); end
      rd(16'hFE01, d, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL oneshot_status got %h want 00", d); end
      rd(16'hFE04, d, s);
      checks++; if (d !== 8'h03) begin errors++; $display("FAIL oneshot_count_lo got %h want 03", d); end
      rd(16'hFE05, d, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL oneshot_count_hi got %h want 00", d); end
   endtask

   task automatic test_w1c_collision;
      logic [7:0] d; logic s;
      wr(16'hFE04, 8'h00);            // count = 3
      wr(16'hFE00, 8'h07);            // E0
      idle(3);                        // past E3
      wr(16'hFE01, 8'h01);            // W1C on expiring edge E4
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_collide_irq got %b want 1", irq); end
      rd(16'hFE01, d, s);             // E5
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL w1c_collide_status got %h want 01", d); end
      wr(16'hFE01, 8'h01);            // E6
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear_irq got %b want 0", irq); end
      wr(16'hFE00, 8'h00);            // E7, stop before E8
      rd(16'hFE01, d, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_status_after got %h want 00", d); end
   endtask

   task automatic test_atomic_read;
      logic [7:0] d; logic s;
      wr(16'hFE06, 8'hFF);
      wr(16'hFE02, 8'h00);
      wr(16'hFE03, 8'h01);
      wr(16'hFE04, 8'h00);            // count = 0x0100
      wr(16'hFE00, 8'h01);            // E0, first tick at E256
      rd(16'hFE04, d, s);
      checks++; if (d !== 8'h00 || s !== 1'b1) begin errors++; $display("FAIL atomic_lo got %h/%b want 00/1", d, s); end
      idle(300);
      rd(16'hFE05, d, s);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL atomic_shadow got %h want 01", d); end
      rd(16'hFE04, d, s);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL atomic_live_lo got %h want ff", d); end
      rd(16'hFE05, d, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL atomic_shadow2 got %h want 00", d); end
      wr(16'hFE00, 8'h00);
   endtask

   task automatic test_decode;
      logic [7:0] d; logic s;
      wr(16'hFDFF, 8'h55);
      wr(16'hFE08, 8'h55);
      rd(16'hFDFF, d, s);
      checks++; if (d !== 8'h00 || s !== 1'b0) begin errors++; $display("FAIL decode_fdff got %h/%b want 00/0", d, s); end
      rd(16'hFE08, d, s);
      checks++; if (d !== 8'h00 || s !== 1'b0) begin errors++; $display("FAIL decode_fe08 got %h/%b want 00/0", d, s); end
      rd(16'hFE00, d, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL decode_ctrl_kept got %h want 00", d); end
      rd(16'hFE06, d, s);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL decode_prescale_kept got %h want ff", d); end
      rd(16'hFE03, d, s);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL decode_reload_hi got %h want 01", d); end
      rd(16'hFE07, d, s);
      checks++; if (d !== 8'h00 || s !== 1'b1) begin errors++; $display("FAIL decode_fe07 got %h/%b want 00/1", d, s); end
   endtask

   task automatic test_async_reset;
      logic [7:0] d; logic s;
      logic [15:0] a;
      wr(16'hFE06, 8'h00);
      wr(16'hFE02, 8'h03);
      wr(16'hFE03, 8'h00);
      wr(16'hFE04, 8'h00);
      wr(16'hFE00, 8'h07);
      idle(6);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL arst_pre_irq got %b want 1", irq); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq_drop got %b want 0", irq); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = 16'hFE00 + 16'(i);
         rd(a, d, s);
         checks++;
         if (d !== 8'h00 || s !== 1'b1) begin errors++; $display("FAIL arst_read_off%0d got %h/%b want 00/1", i, d, s); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_auto_reload();
      test_one_shot();
      test_w1c_collision();
      test_atomic_read();
      test_decode();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
